// File: rtl/axi4lite_console_port.sv
// axi4lite_console_port: AXI4-lite MMIO slave with a console byte FIFO, a sticky pass flag and a sticky
// undecoded-address flag. Define CONSOLE_DROP_EN to drop (and count) bytes written to a full FIFO instead of stalling.
module axi4lite_console_port #(
    parameter int unsigned DEPTH        = 16,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,
    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,
    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,
    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,
    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tests_passed,
    output logic        addr_err,
    output logic [1:0]  dbg_wr_state_o,
    output logic        dbg_rd_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high; a valid, once
    // raised, is held with its payload stable until that edge.
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_e;

    w_state_e w_state_q;
    r_state_e r_state_q;

    logic        awready_q, wready_q, bvalid_q;
    logic        aw_held_q, w_held_q;
    logic [31:0] awaddr_q, wdata_q;
    logic        wstrb0_q;
    logic        tests_passed_q;
    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q;
    logic        addr_err_q;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;

    logic        aw_hs, w_hs, ar_hs, aw_have, w_have;
    logic        wr_console, wr_pass, wr_push_req, wr_stall;
    logic        push, pop, fifo_full, fifo_empty;
    logic        wr_bad, rd_bad;
    logic [7:0]  level8;
    logic [15:0] drop_cnt;
    logic [31:0] rd_value_d;
    logic        unused_ok;

    assign unused_ok = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_wstrb[3:1]};

    assign aw_hs   = mem_axi_awvalid && awready_q;
    assign w_hs    = mem_axi_wvalid && wready_q;
    assign ar_hs   = mem_axi_arvalid && arready_q;
    assign aw_have = aw_held_q || aw_hs;
    assign w_have  = w_held_q || w_hs;

    assign wr_console  = (awaddr_q == CONSOLE_ADDR);
    assign wr_pass     = (awaddr_q == PASS_ADDR);
    assign wr_push_req = (w_state_q == W_EXEC) && wr_console && wstrb0_q;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == (AW + 1)'(DEPTH));
    assign pop        = !fifo_empty && tx_ready;
    // A full FIFO still accepts the byte when the head leaves on the same edge.
    assign push       = wr_push_req && (!fifo_full || pop);

`ifdef CONSOLE_DROP_EN
    logic        drop;
    logic [15:0] drop_cnt_q;

    assign drop     = wr_push_req && fifo_full && !pop;
    assign wr_stall = 1'b0;
    assign drop_cnt = drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 16'h0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`else
    assign wr_stall = wr_push_req && fifo_full && !pop;
    assign drop_cnt = 16'h0;
`endif

    // Write channel: collect AW and W in any order, execute once, then respond.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q      <= W_IDLE;
            awready_q      <= 1'b0;
            wready_q       <= 1'b0;
            bvalid_q       <= 1'b0;
            aw_held_q      <= 1'b0;
            w_held_q       <= 1'b0;
            awaddr_q       <= 32'h0;
            wdata_q        <= 32'h0;
            wstrb0_q       <= 1'b0;
            tests_passed_q <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q  <= mem_axi_awaddr;
                        aw_held_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q  <= mem_axi_wdata;
                        wstrb0_q <= mem_axi_wstrb[0];
                        w_held_q <= 1'b1;
                    end
                    if (aw_have && w_have) begin
                        w_state_q <= W_EXEC;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else begin
                        awready_q <= !aw_have;
                        wready_q  <= !w_have;
                    end
                end
                W_EXEC: begin
                    if (!wr_stall) begin
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        if (wr_pass && (wdata_q == PASS_VALUE)) begin
                            tests_passed_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (mem_axi_bready) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    assign level8 = 8'(level_q);

    always_comb begin
        rd_value_d = 32'hDEAD_BEEF;
        if (mem_axi_araddr == CONSOLE_ADDR + 32'd4) begin
            rd_value_d = {drop_cnt, 7'b0, fifo_full, level8};
        end else if (mem_axi_araddr == CONSOLE_ADDR) begin
            rd_value_d = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        r_state_q <= R_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_value_d;
                    end
                end
                R_RESP: begin
                    if (mem_axi_rready) begin
                        r_state_q <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign wr_bad = (w_state_q == W_EXEC) && !wr_console && !wr_pass;
    assign rd_bad = ar_hs && (mem_axi_araddr != CONSOLE_ADDR) && (mem_axi_araddr != CONSOLE_ADDR + 32'd4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else if (wr_bad || rd_bad) begin
            addr_err_q <= 1'b1;
        end
    end

    // Storage is not reset: emptiness is carried entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata_q[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign mem_axi_awready = awready_q;
    assign mem_axi_wready  = wready_q;
    assign mem_axi_bvalid  = bvalid_q;
    assign mem_axi_arready = arready_q;
    assign mem_axi_rvalid  = rvalid_q;
    assign mem_axi_rdata   = rdata_q;
    assign tx_valid        = !fifo_empty;
    assign tx_data         = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign tests_passed    = tests_passed_q;
    assign addr_err        = addr_err_q;
    assign dbg_wr_state_o  = w_state_q;
    assign dbg_rd_state_o  = r_state_q;

endmodule

// File: tb/tb_axi4lite_console_port.sv
// Directed bench for axi4lite_console_port: write/read channels, console FIFO, pass flag, address errors, reset.
module tb_axi4lite_console_port;

  localparam logic [31:0] CON  = 32'h1000_0000;
  localparam logic [31:0] STAT = 32'h1000_0004;
  localparam logic [31:0] PASS = 32'h2000_0000;
  localparam logic [31:0] BAD  = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b1;
  logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic        tx_valid, tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tests_passed, addr_err;
  logic [1:0]  dbg_wr_state;
  logic        dbg_rd_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  axi4lite_console_port dut (
    .clk(clk), .reset(reset),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tests_passed(tests_passed), .addr_err(addr_err),
    .dbg_wr_state_o(dbg_wr_state), .dbg_rd_state_o(dbg_rd_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // drivers
  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic aw_w_issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, output bit ok);
    int cyc;
    bit aw_done, w_done, aw_f, w_f;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = (lead <= 0);
    wvalid = (lead >= 0);
    while (!(aw_done && w_done) && cyc < 100) begin
      aw_f = awvalid && awready;
      w_f = wvalid && wready;
      @(posedge clk); #1;
      cyc++;
      if (aw_f) begin awvalid = 1'b0; aw_done = 1; end
      if (w_f) begin wvalid = 1'b0; w_done = 1; end
      if (!aw_done && !awvalid && cyc >= lead) awvalid = 1'b1;
      if (!w_done && !wvalid && cyc >= -lead) wvalid = 1'b1;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    ok = aw_done && w_done;
  endtask

  task automatic wait_b(output int lat);
    lat = 0;
    while (!bvalid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bvalid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, output int lat);
    bit ok;
    aw_w_issue(addr, data, strb, lead, ok);
    if (!ok) lat = -1;
    else wait_b(lat);
  endtask

  task automatic ar_issue(input logic [31:0] addr, output bit ok);
    int cyc;
    bit f;
    cyc = 0; ok = 0;
    araddr = addr;
    arvalid = 1'b1;
    while (!ok && cyc < 100) begin
      f = arvalid && arready;
      @(posedge clk); #1;
      cyc++;
      if (f) ok = 1;
    end
    arvalid = 1'b0;
  endtask

  task automatic read_finish();
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic pop_one(output logic [7:0] d, output logic v);
    v = tx_valid;
    d = tx_data;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin errors++; $display("FAIL reset_handshake: got %b expected 00000", {awready, wready, bvalid, arready, rvalid}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    checks++; if ({tx_valid, tests_passed, addr_err} !== 3'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000", {tx_valid, tests_passed, addr_err}); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL idle_ready: got %b expected 111", {awready, wready, arready}); end
  endtask

  task automatic test_console_write();
    int lat;
    logic [7:0] d;
    logic v;
    do_write(CON, 32'h0000_0041, 4'b0001, 0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL t1_latency: got %0d expected 1", lat); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL t1_tx: got v=%b d=%h expected v=1 d=41", tx_valid, tx_data); end
    pop_one(d, v);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL t1_pop: got tx_valid=%b expected 0", tx_valid); end
    do_write(CON, 32'h0000_0042, 4'b1110, -2, lat);
    checks++; if (lat !== 1 || tx_valid !== 1'b0) begin errors++; $display("FAIL no_strb0: got lat=%0d tx_valid=%b expected lat=1 tx_valid=0", lat, tx_valid); end
  endtask

  task automatic test_pass_flag();
    int lat;
    do_write(PASS, 32'd5, 4'b1111, 2, lat);
    checks++; if (lat !== 1 || tests_passed !== 1'b0) begin errors++; $display("FAIL pass_wrong_value: got lat=%0d passed=%b expected lat=1 passed=0", lat, tests_passed); end
    do_write(PASS, 32'd123456789, 4'b1111, 2, lat);
    checks++; if (lat !== 1 || tests_passed !== 1'b1) begin errors++; $display("FAIL pass_set: got lat=%0d passed=%b expected lat=1 passed=1", lat, tests_passed); end
    do_write(PASS, 32'd5, 4'b1111, 0, lat);
    checks++; if (tests_passed !== 1'b1 || addr_err !== 1'b0) begin errors++; $display("FAIL pass_sticky: got passed=%b addr_err=%b expected passed=1 addr_err=0", tests_passed, addr_err); end
  endtask

  task automatic test_status_read();
    int lat;
    bit ok;
    logic [7:0] d;
    logic v;
    for (int i = 0; i < 3; i++) begin
      do_write(CON, 32'h0000_00A1 + i, 4'b0001, 0, lat);
      exp_q.push_back(8'hA1 + 8'(i));
    end
    ar_issue(STAT, ok);
    checks++; if (!ok || rvalid !== 1'b1) begin errors++; $display("FAIL t4_rvalid: got ok=%b rvalid=%b expected 1 1", ok, rvalid); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rvalid !== 1'b1 || rdata !== 32'h0000_0003) begin errors++; $display("FAIL t4_hold: cycle %0d got rvalid=%b rdata=%h expected 1 00000003", i, rvalid, rdata); end
      @(posedge clk); #1;
    end
    read_finish();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL t4_rdone: got rvalid=%b expected 0", rvalid); end
    ar_issue(CON, ok);
    checks++; if (rdata !== 32'h0 || addr_err !== 1'b0) begin errors++; $display("FAIL read_con: got rdata=%h addr_err=%b expected 00000000 0", rdata, addr_err); end
    read_finish();
    while (exp_q.size() > 0) begin
      pop_one(d, v);
      checks++; if (v !== 1'b1 || d !== exp_q[0]) begin errors++; $display("FAIL t4_drain: got v=%b d=%h expected v=1 d=%h", v, d, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_concurrent();
    int lat;
    bit ok;
    logic [31:0] rd;
    logic [7:0] d;
    logic v;
    fork
      do_write(CON, 32'h0000_005A, 4'b0001, 0, lat);
      begin
        ar_issue(STAT, ok);
        rd = rdata;
        read_finish();
      end
    join
    checks++; if (lat !== 1 || rd !== 32'h0) begin errors++; $display("FAIL concurrent: got lat=%0d status=%h expected 1 00000000", lat, rd); end
    pop_one(d, v);
    checks++; if (v !== 1'b1 || d !== 8'h5A) begin errors++; $display("FAIL concurrent_tx: got v=%b d=%h expected 1 5a", v, d); end
  endtask

  task automatic test_fifo_full();
    int lat;
    bit ok;
    logic [7:0] d;
    logic v;
    for (int i = 0; i < 16; i++) begin
      do_write(CON, 32'h0000_00C0 + i, 4'b0001, 0, lat);
      exp_q.push_back(8'hC0 + 8'(i));
    end
    checks++; if (lat !== 1 || tx_data !== 8'hC0) begin errors++; $display("FAIL t3_fill: got lat=%0d head=%h expected 1 c0", lat, tx_data); end
`ifdef CONSOLE_DROP_EN
    do_write(CON, 32'h0000_00D0, 4'b0001, 0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL t3_drop_latency: got %0d expected 1", lat); end
    ar_issue(STAT, ok);
    checks++; if (rdata !== 32'h0001_0110) begin errors++; $display("FAIL t3_drop_status: got %h expected 00010110", rdata); end
    read_finish();
`else
    aw_w_issue(CON, 32'h0000_00D0, 4'b0001, 0, ok);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL t3_stall: cycle %0d got bvalid=%b expected 0", i, bvalid); end
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'hD0);
    checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL t3_release: got bvalid=%b expected 1", bvalid); end
    @(posedge clk); #1;
    ar_issue(STAT, ok);
    checks++; if (rdata !== 32'h0000_0110) begin errors++; $display("FAIL t3_status: got %h expected 00000110", rdata); end
    read_finish();
`endif
    while (exp_q.size() > 0) begin
      pop_one(d, v);
      checks++; if (v !== 1'b1 || d !== exp_q[0]) begin errors++; $display("FAIL t3_drain: got v=%b d=%h expected v=1 d=%h", v, d, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL t3_empty: got tx_valid=%b expected 0", tx_valid); end
  endtask

  task automatic test_addr_err();
    int lat;
    bit ok;
    do_reset();
    ar_issue(BAD, ok);
    checks++; if (rdata !== 32'hDEAD_BEEF || addr_err !== 1'b1) begin errors++; $display("FAIL bad_read: got rdata=%h addr_err=%b expected deadbeef 1", rdata, addr_err); end
    read_finish();
    do_reset();
    do_write(BAD, 32'h0000_0041, 4'b1111, 0, lat);
    checks++; if (lat !== 1 || addr_err !== 1'b1) begin errors++; $display("FAIL bad_write: got lat=%0d addr_err=%b expected 1 1", lat, addr_err); end
    checks++; if (tx_valid !== 1'b0 || tests_passed !== 1'b0) begin errors++; $display("FAIL bad_write_side: got tx_valid=%b passed=%b expected 0 0", tx_valid, tests_passed); end
    do_reset();
    do_write(STAT, 32'h0000_0041, 4'b0001, 0, lat);
    checks++; if (addr_err !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL status_write: got addr_err=%b tx_valid=%b expected 1 0", addr_err, tx_valid); end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    bit ok;
    logic [7:0] d;
    logic v;
    do_reset();
    do_write(PASS, 32'd123456789, 4'b1111, 0, lat);
    do_write(CON, 32'h0000_0055, 4'b0001, 0, lat);
    aw_w_issue(CON, 32'h0000_0066, 4'b0001, 0, ok);
    reset = 1'b1;
    #1;
    checks++; if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin errors++; $display("FAIL t6_handshake: got %b expected 00000", {awready, wready, bvalid, arready, rvalid}); end
    checks++; if ({tx_valid, tx_data, tests_passed, addr_err, rdata} !== 43'h0) begin errors++; $display("FAIL t6_outputs: got tx_valid=%b tx_data=%h passed=%b addr_err=%b rdata=%h expected all 0", tx_valid, tx_data, tests_passed, addr_err, rdata); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bvalid !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL t6_after: cycle %0d got bvalid=%b tx_valid=%b expected 0 0", i, bvalid, tx_valid); end
    end
    do_write(CON, 32'h0000_0041, 4'b0001, 0, lat);
    checks++; if (lat !== 1 || tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL t6_fresh: got lat=%0d v=%b d=%h expected 1 1 41", lat, tx_valid, tx_data); end
    pop_one(d, v);
  endtask

  initial begin
    test_reset();
    test_console_write();
    test_pass_flag();
    test_status_read();
    test_concurrent();
    test_fifo_full();
    test_addr_err();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
